// File: rtl/tlc_pkg.sv
// Purpose : shared types, lamp encodings and round-robin search for the traffic-light controller.
// Latency : n/a (types, constants and a pure combinational function).
// Backpr. : n/a.
package tlc_pkg;

   // Phase of the approach that currently owns the right-of-way.
   typedef enum logic [1:0] {
      ALLRED = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } tlc_state_t;

   // Largest supported approach count; sizes the search function's input.
   localparam int MAX_APP = 8;

   // One lamp head: exactly one field is set for any legal code.
   typedef struct packed {
      logic red;
      logic ylw;
      logic grn;
   } lamp_t;

   localparam lamp_t LAMP_RED = '{red: 1'b1, ylw: 1'b0, grn: 1'b0};
   localparam lamp_t LAMP_YLW = '{red: 1'b0, ylw: 1'b1, grn: 1'b0};
   localparam lamp_t LAMP_GRN = '{red: 1'b0, ylw: 1'b0, grn: 1'b1};

   // First approach with latched demand, scanning cur+1, cur+2, ... with wrap
   // (cur itself is visited last). With nothing latched, hand over to cur+1.
   function automatic int rr_next(input logic [MAX_APP-1:0] dem, input int cur, input int n);
      int   pick;
      logic found;
      pick  = (cur + 1) % n;
      found = 1'b0;
      for (int k = 1; k <= MAX_APP; k++) begin
         if (!found && (k <= n) && dem[(cur + k) % n]) begin
            pick  = (cur + k) % n;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Purpose : divides the clock into a timing tick; test mode makes every cycle a tick.
// Latency : tick is combinational from the counter and registered test flag.
// Backpr. : none; free-running.
// Ports   : ck, clr_n (sync, active-low), test (registered bypass), tick (strobe).
module tlc_prescaler
   import tlc_pkg::*;
#(
   parameter int PRE_DIV = 200
) (
   input  logic ck,
   input  logic clr_n,
   input  logic test,
   output logic tick
);

   localparam int            CW   = $clog2(PRE_DIV);
   localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

   logic [CW-1:0] pre_cnt;

   // Held at zero in test mode, so leaving test mode restarts a full period.
   always_ff @(posedge ck) begin
      if (!clr_n) begin
         pre_cnt <= '0;
      end else if (test || (pre_cnt == LAST)) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + CW'(1);
      end
   end

   assign tick = test | (pre_cnt == LAST);

endmodule

// File: rtl/tlc_multi_phase.sv
// Purpose : N-approach traffic-light controller with demand latches, min/max green, yellow and all-red.
// Latency : inputs registered once; lamps registered one cycle after the phase state.
// Backpr. : none; sensors are level inputs, lamps are free-running outputs.
// Ports   : CK, CLR_N (sync, active-low), TEST (tick every cycle), FM[N_APP] demand sensors,
//           GRN/YLW/RED[N_APP] lamps, ACTIVE right-of-way owner, TICK registered tick strobe.
//           Optional EMG[N_APP] emergency preemption when TLC_PREEMPT_EN is defined.
module tlc_multi_phase
   import tlc_pkg::*;
#(
   parameter int N_APP    = 2,
   parameter int PRE_DIV  = 200,
   parameter int T_W      = 6,
   parameter int GRN_MIN  = 8,
   parameter int GRN_MAX  = 24,
   parameter int YLW_T    = 3,
   parameter int ALLRED_T = 1
) (
   input  logic                     CK,
   input  logic                     CLR_N,
   input  logic                     TEST,
   input  logic [N_APP-1:0]         FM,
   output logic [N_APP-1:0]         GRN,
   output logic [N_APP-1:0]         YLW,
   output logic [N_APP-1:0]         RED,
   output logic [$clog2(N_APP)-1:0] ACTIVE,
   output logic                     TICK
`ifdef TLC_PREEMPT_EN
   ,
   input  logic [N_APP-1:0]         EMG
`endif
);

   localparam int             AW          = $clog2(N_APP);
   localparam logic [T_W-1:0] ALLRED_LAST = T_W'(ALLRED_T - 1);
   localparam logic [T_W-1:0] YLW_LAST    = T_W'(YLW_T - 1);
   localparam logic [T_W-1:0] GMIN_LAST   = T_W'(GRN_MIN - 1);
   localparam logic [T_W-1:0] GMAX_LAST   = T_W'(GRN_MAX - 1);

   logic [N_APP-1:0]   fm_s;
   logic               test_s;
   logic               tick;
   tlc_state_t         state, state_n;
   logic [T_W-1:0]     tmr, tmr_n;
   logic [AW-1:0]      active, active_n, nxt;
   logic [N_APP-1:0]   dem, dem_n;
   logic [MAX_APP-1:0] dem_ext;
   logic               others;
   logic               green_done;
   lamp_t              cur_lamp;
   logic [N_APP-1:0]   grn_d, ylw_d, red_d;

   // ---------------------------------------------------------------- inputs
`ifdef TLC_PREEMPT_EN
   logic [N_APP-1:0] emg_s;
   logic             emg_any;
   logic [AW-1:0]    emg_k;

   always_ff @(posedge CK) begin
      if (!CLR_N) emg_s <= '0;
      else        emg_s <= EMG;
   end

   // Lowest-numbered requester wins.
   always_comb begin
      emg_any = |emg_s;
      emg_k   = '0;
      for (int i = N_APP - 1; i >= 0; i--) begin
         if (emg_s[i]) emg_k = AW'(i);
      end
   end
`endif

   always_ff @(posedge CK) begin
      if (!CLR_N) begin
         fm_s   <= '0;
         test_s <= 1'b0;
      end else begin
         fm_s   <= FM;
         test_s <= TEST;
      end
   end

   tlc_prescaler #(.PRE_DIV(PRE_DIV)) u_prescaler (
      .ck    (CK),
      .clr_n (CLR_N),
      .test  (test_s),
      .tick  (tick)
   );

   // ------------------------------------------------------ demand decisions
   always_comb begin
      dem_ext            = '0;
      dem_ext[N_APP-1:0] = dem;
      nxt                = AW'(rr_next(dem_ext, int'(active), N_APP));
      others             = 1'b0;
      for (int j = 0; j < N_APP; j++) begin
         if (dem[j] && (AW'(j) != active)) others = 1'b1;
      end
   end

   // Green yields only to competing demand; a still-occupied approach keeps
   // green until the timer saturates at the maximum.
   assign green_done = tick && (tmr >= GMIN_LAST) && others &&
                       (!fm_s[active] || (tmr == GMAX_LAST));

   // --------------------------------------------------------------- FSM
   always_ff @(posedge CK) begin
      if (!CLR_N) begin
         state  <= ALLRED;
         tmr    <= '0;
         active <= AW'(N_APP - 1);
         dem    <= '0;
      end else begin
         state  <= state_n;
         tmr    <= tmr_n;
         active <= active_n;
         dem    <= dem_n;
      end
   end

   always_comb begin
      state_n  = state;
      active_n = active;
      tmr_n    = tmr;
      dem_n    = dem | fm_s;
      if (state == GREEN) dem_n[active] = 1'b0;

      case (state)
         ALLRED: begin
            if (tick && (tmr == ALLRED_LAST)) begin
               state_n = GREEN;
`ifdef TLC_PREEMPT_EN
               active_n = emg_any ? emg_k : nxt;
`else
               active_n = nxt;
`endif
            end
         end
         GREEN: begin
`ifdef TLC_PREEMPT_EN
            // Preemption skips the minimum green; a preempting owner holds.
            if (emg_any) begin
               if (emg_k != active) state_n = YELLOW;
            end else if (green_done) begin
               state_n = YELLOW;
            end
`else
            if (green_done) state_n = YELLOW;
`endif
         end
         YELLOW: begin
            if (tick && (tmr == YLW_LAST)) state_n = ALLRED;
         end
         default: state_n = ALLRED;
      endcase

      if (state_n != state) begin
         tmr_n = '0;
      end else if (tick && (tmr != GMAX_LAST)) begin
         tmr_n = tmr + T_W'(1);
      end

      // Entering green consumes that approach's demand (overrides a new set).
      if ((state == ALLRED) && (state_n == GREEN)) dem_n[active_n] = 1'b0;
   end

   // --------------------------------------------------------------- lamps
   always_comb begin
      case (state)
         GREEN:   cur_lamp = LAMP_GRN;
         YELLOW:  cur_lamp = LAMP_YLW;
         default: cur_lamp = LAMP_RED;
      endcase
      grn_d = '0;
      ylw_d = '0;
      red_d = '0;
      for (int i = 0; i < N_APP; i++) begin
         if (AW'(i) == active) begin
            grn_d[i] = cur_lamp.grn;
            ylw_d[i] = cur_lamp.ylw;
            red_d[i] = cur_lamp.red;
         end else begin
            grn_d[i] = LAMP_RED.grn;
            ylw_d[i] = LAMP_RED.ylw;
            red_d[i] = LAMP_RED.red;
         end
      end
   end

   always_ff @(posedge CK) begin
      if (!CLR_N) begin
         GRN  <= '0;
         YLW  <= '0;
         RED  <= '1;
         TICK <= 1'b0;
      end else begin
         GRN  <= grn_d;
         YLW  <= ylw_d;
         RED  <= red_d;
         TICK <= tick;
      end
   end

   assign ACTIVE = active;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Purpose : self-checking bench for tlc_multi_phase (directed vectors plus randomized reference model).
// Latency : n/a.
// Backpr. : n/a.
module tb_tlc_multi_phase;

   localparam int N        = 2;
   localparam int PRE_DIV  = 4;
   localparam int GRN_MIN  = 3;
   localparam int GRN_MAX  = 6;
   localparam int YLW_T    = 2;
   localparam int ALLRED_T = 1;

   localparam int PH_R = 0;
   localparam int PH_G = 1;
   localparam int PH_Y = 2;

   logic         ck = 1'b0;
   logic         clr_n = 1'b0;
   logic         test = 1'b0;
   logic [N-1:0] fm = '0;
   logic [N-1:0] grn, ylw, red;
   logic         active;
   logic         tick;
`ifdef TLC_PREEMPT_EN
   logic [N-1:0] emg = '0;
`endif

   tlc_multi_phase #(
      .N_APP(N), .PRE_DIV(PRE_DIV), .T_W(6), .GRN_MIN(GRN_MIN),
      .GRN_MAX(GRN_MAX), .YLW_T(YLW_T), .ALLRED_T(ALLRED_T)
   ) dut (
      .CK(ck), .CLR_N(clr_n), .TEST(test), .FM(fm),
      .GRN(grn), .YLW(ylw), .RED(red), .ACTIVE(active), .TICK(tick)
`ifdef TLC_PREEMPT_EN
      , .EMG(emg)
`endif
   );

   always #5 ck = ~ck;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------------------------------------------- reference model
   // Phase-level view: who owns the road, how many ticks the phase has lasted
   // (unbounded), which approaches are waiting, and cycles since test mode ended.
   int           m_phase, m_age, m_owner, m_run;
   logic [N-1:0] m_wait, m_fm_s;
   logic         m_test_s;
   logic [N-1:0] m_grn, m_ylw, m_red;
   logic         m_tick;

   task automatic model_reset();
      m_phase = PH_R; m_age = 0; m_owner = N - 1; m_run = 0;
      m_wait = '0; m_fm_s = '0; m_test_s = 1'b0;
      m_grn = '0; m_ylw = '0; m_red = '1; m_tick = 1'b0;
   endtask

   task automatic model_edge();
      bit           tk, others;
      int           nxt, ph_n;
      logic [N-1:0] w_n;
      if (!clr_n) begin
         model_reset();
         return;
      end
      tk = m_test_s || ((m_run % PRE_DIV) == PRE_DIV - 1);
      // lamps show the phase as it stood before this edge
      m_grn = '0; m_ylw = '0; m_red = '1;
      if (m_phase == PH_G) begin m_grn[m_owner] = 1'b1; m_red[m_owner] = 1'b0; end
      else if (m_phase == PH_Y) begin m_ylw[m_owner] = 1'b1; m_red[m_owner] = 1'b0; end
      m_tick = tk;
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_owner && m_wait[j]) others = 1;
      w_n = m_wait | m_fm_s;
      if (m_phase == PH_G) w_n[m_owner] = 1'b0;
      ph_n = m_phase;
      if (tk) begin
         if (m_phase == PH_R && m_age == ALLRED_T - 1) begin
            nxt = (m_owner + 1) % N;
            for (int off = N; off >= 1; off--)
               if (m_wait[(m_owner + off) % N]) nxt = (m_owner + off) % N;
            ph_n = PH_G; m_owner = nxt; w_n[nxt] = 1'b0;
         end else if (m_phase == PH_G && m_age >= GRN_MIN - 1 && others &&
                      (!m_fm_s[m_owner] || m_age >= GRN_MAX - 1)) begin
            ph_n = PH_Y;
         end else if (m_phase == PH_Y && m_age == YLW_T - 1) begin
            ph_n = PH_R;
         end
      end
      if (ph_n != m_phase) m_age = 0;
      else if (tk) m_age++;
      m_phase  = ph_n;
      m_wait   = w_n;
      m_run    = m_test_s ? 0 : m_run + 1;
      m_fm_s   = fm;
      m_test_s = test;
   endtask

   task automatic step();
      @(posedge ck);
      model_edge();
      #1;
      chk("model", 16'({grn, ylw, red, active, tick}),
          16'({m_grn, m_ylw, m_red, 1'(m_owner), m_tick}));
   endtask

   // ----------------------------------------------------- directed table
   typedef struct {
      string    name;
      bit       clr_n;
      bit       test;
      logic [1:0] fm;
      int       n;
      logic [1:0] grn, ylw, red;
      logic     act, tk;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input string nm, input bit c, input bit t, input logic [1:0] f, input int n,
                      input logic [1:0] g, input logic [1:0] y, input logic [1:0] r,
                      input logic a, input logic k);
      vec_t v;
      v.name = nm; v.clr_n = c; v.test = t; v.fm = f; v.n = n;
      v.grn = g; v.ylw = y; v.red = r; v.act = a; v.tk = k;
      tbl.push_back(v);
   endtask

   initial begin
      model_reset();
      //   name          clr test fm    n   grn    ylw    red    act  tick
      add("reset",        0, 1, 2'b00, 2, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      add("allred_tick",  1, 1, 2'b00, 2, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
      add("first_green",  1, 1, 2'b00, 1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("green_rests",  1, 1, 2'b00, 20, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("fm1_pulse",    1, 1, 2'b10, 1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("pre_yellow",   1, 1, 2'b00, 2, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("yellow0_a",    1, 1, 2'b00, 1, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1);
      add("yellow0_b",    1, 1, 2'b00, 1, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1);
      add("allred_to1",   1, 1, 2'b00, 1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1);
      add("green1",       1, 1, 2'b00, 1, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
      add("green1_rest",  1, 1, 2'b00, 10, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
      add("both_hold",    1, 1, 2'b11, 3, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
      add("yellow1_a",    1, 1, 2'b11, 1, 2'b00, 2'b10, 2'b01, 1'b1, 1'b1);
      add("yellow1_b",    1, 1, 2'b11, 1, 2'b00, 2'b10, 2'b01, 1'b1, 1'b1);
      add("allred_to0",   1, 1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
      add("gmax0_start",  1, 1, 2'b11, 1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("gmax0_end",    1, 1, 2'b11, 5, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("gmax0_ylw",    1, 1, 2'b11, 1, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1);
      add("gmax0_ylw2",   1, 1, 2'b11, 1, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1);
      add("alt_to1",      1, 1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1);
      add("gmax1_start",  1, 1, 2'b11, 1, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
      add("gmax1_end",    1, 1, 2'b11, 5, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
      add("gmax1_ylw",    1, 1, 2'b11, 1, 2'b00, 2'b10, 2'b01, 1'b1, 1'b1);
      add("clr_mid_ylw",  0, 1, 2'b11, 1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      add("reset_slow",   0, 0, 2'b00, 2, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      add("slow_no_tick", 1, 0, 2'b00, 3, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      add("slow_tick1",   1, 0, 2'b00, 1, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
      add("slow_green",   1, 0, 2'b00, 1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
      add("slow_tick2",   1, 0, 2'b00, 3, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("slow_gmin",    1, 0, 2'b10, 8, 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);
      add("slow_ylw",     1, 0, 2'b10, 1, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0);

      #2;
      foreach (tbl[r]) begin
         clr_n = tbl[r].clr_n;
         test  = tbl[r].test;
         fm    = tbl[r].fm;
         repeat (tbl[r].n) step();
         chk(tbl[r].name, 16'({grn, ylw, red, active, tick}),
             16'({tbl[r].grn, tbl[r].ylw, tbl[r].red, tbl[r].act, tbl[r].tk}));
      end

      // ------------------------------------------- randomized vs model
      clr_n = 1'b0; test = 1'b0; fm = '0;
      step(); step();
      clr_n = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) test = ~test;
         for (int i = 0; i < N; i++) if ($urandom_range(0, 24) == 0) fm[i] = ~fm[i];
         clr_n = ($urandom_range(0, 799) != 0);
         step();
      end

      // ------------------------- leaving test mode restarts the prescaler
      clr_n = 1'b1; test = 1'b1;
      repeat (3) step();
      test = 1'b0;
      step();
      chk("restart_last_fast_tick", 16'(tick), 16'(1));
      repeat (3) begin
         step();
         chk("restart_gap", 16'(tick), 16'(0));
      end
      step();
      chk("restart_first_slow_tick", 16'(tick), 16'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
